// File: rtl/axi_sram_slave.sv
// AXI4-Lite responder over a word-addressed SRAM array.
// Read and write channels run independent FSMs with programmable response latency.
module axi_sram_slave #(
    parameter logic [31:0] BASE   = 32'h80000000,
    parameter int          DEPTH  = 4096,
    parameter int          RD_LAT = 2,
    parameter int          WR_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [7:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    localparam int          AW    = $clog2(DEPTH);
    localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

    logic [31:0] mem [DEPTH];

    function automatic logic in_range(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < LIMIT;
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off[AW+1:2];
    endfunction

    // ---------------- read channel ----------------
    r_state_t    r_state, r_next;
    logic [15:0] rcnt;
    logic [31:0] ar_addr_q;
    logic [31:0] rd_addr;

    // With RD_LAT=0 the response loads on the handshake edge, before the address is latched.
    assign rd_addr = (r_state == R_IDLE) ? araddr : ar_addr_q;

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE: if (arvalid) r_next = (RD_LAT == 0) ? R_RESP : R_WAIT;
            R_WAIT: if (rcnt == 16'd1) r_next = R_RESP;
            R_RESP: if (rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= R_IDLE;
            arready   <= 1'b1;
            rvalid    <= 1'b0;
            rdata     <= 32'h0;
            rresp     <= 2'b00;
            rcnt      <= 16'h0;
            ar_addr_q <= 32'h0;
        end else begin
            r_state <= r_next;
            arready <= (r_next == R_IDLE);
            rvalid  <= (r_next == R_RESP);
            if (r_state == R_IDLE && arvalid) begin
                ar_addr_q <= araddr;
                rcnt      <= 16'(RD_LAT);
            end else if (r_state == R_WAIT) begin
                rcnt <= rcnt - 16'd1;
            end
            if (r_next == R_RESP && r_state != R_RESP) begin
                if (in_range(rd_addr)) begin
                    rdata <= mem[word_idx(rd_addr)];
                    rresp <= 2'b00;
                end else begin
                    rdata <= 32'h0;
                    rresp <= 2'b10;
                end
            end
        end
    end

    // ---------------- write channel ----------------
    w_state_t    w_state, w_next;
    logic [15:0] wcnt;
    logic        aw_got, w_got, aw_got_n, w_got_n;
    logic [31:0] aw_addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        aw_hs, w_hs, both_held, commit;
    logic [31:0] eff_addr, eff_data;
    logic [3:0]  eff_strb;
    logic        unused_strb_hi;

    assign unused_strb_hi = ^wstrb[7:4];

    assign aw_hs     = awvalid & awready;
    assign w_hs      = wvalid & wready;
    assign both_held = (aw_got | aw_hs) & (w_got | w_hs);
    // Same-cycle handshakes feed the commit directly when WR_LAT=0.
    assign eff_addr  = aw_got ? aw_addr_q : awaddr;
    assign eff_data  = w_got ? wdata_q : wdata;
    assign eff_strb  = w_got ? wstrb_q : wstrb[3:0];

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE: if (both_held) w_next = (WR_LAT == 0) ? W_RESP : W_WAIT;
            W_WAIT: if (wcnt == 16'd1) w_next = W_RESP;
            W_RESP: if (bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        commit   = (w_next == W_RESP) && (w_state != W_RESP);
        aw_got_n = aw_got | aw_hs;
        w_got_n  = w_got | w_hs;
        if (w_state == W_RESP && bready) begin
            aw_got_n = 1'b0;
            w_got_n  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state   <= W_IDLE;
            awready   <= 1'b1;
            wready    <= 1'b1;
            bvalid    <= 1'b0;
            bresp     <= 2'b00;
            wcnt      <= 16'h0;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            aw_addr_q <= 32'h0;
            wdata_q   <= 32'h0;
            wstrb_q   <= 4'h0;
        end else begin
            w_state <= w_next;
            aw_got  <= aw_got_n;
            w_got   <= w_got_n;
            awready <= (w_next == W_IDLE) && !aw_got_n;
            wready  <= (w_next == W_IDLE) && !w_got_n;
            bvalid  <= (w_next == W_RESP);
            if (aw_hs) aw_addr_q <= awaddr;
            if (w_hs) begin
                wdata_q <= wdata;
                wstrb_q <= wstrb[3:0];
            end
            if (w_state == W_IDLE && both_held) wcnt <= 16'(WR_LAT);
            else if (w_state == W_WAIT)         wcnt <= wcnt - 16'd1;
            if (commit) bresp <= in_range(eff_addr) ? 2'b00 : 2'b10;
        end
    end

    // Array has no reset; a reset edge suppresses any commit in flight.
    always_ff @(posedge clk) begin
        if (!rst && commit && in_range(eff_addr)) begin
            for (int i = 0; i < 4; i++)
                if (eff_strb[i]) mem[word_idx(eff_addr)][8*i +: 8] <= eff_data[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: latency, strobes, ordering, range, stalls, reset.
module tb_axi_sram_slave;
    logic clk = 1'b0;
    logic rst, b_rst;
    always #5 clk = ~clk;

    logic [31:0] araddr, awaddr, wdata, rdata;
    logic        arvalid, rready, awvalid, wvalid, bready;
    logic [7:0]  wstrb;
    logic        arready, rvalid, awready, wready, bvalid;
    logic [1:0]  rresp, bresp;

    logic [31:0] b_araddr, b_awaddr, b_wdata, b_rdata;
    logic        b_arvalid, b_rready, b_awvalid, b_wvalid, b_bready;
    logic [7:0]  b_wstrb;
    logic        b_arready, b_rvalid, b_awready, b_wready, b_bvalid;
    logic [1:0]  b_rresp, b_bresp;

    axi_sram_slave #(.BASE(32'h80000000), .DEPTH(4096), .RD_LAT(2), .WR_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready));

    axi_sram_slave #(.BASE(32'h80000000), .DEPTH(4096), .RD_LAT(0), .WR_LAT(3)) dut_b (
        .clk(clk), .rst(b_rst),
        .araddr(b_araddr), .arvalid(b_arvalid), .arready(b_arready),
        .rdata(b_rdata), .rresp(b_rresp), .rvalid(b_rvalid), .rready(b_rready),
        .awaddr(b_awaddr), .awvalid(b_awvalid), .awready(b_awready),
        .wdata(b_wdata), .wstrb(b_wstrb), .wvalid(b_wvalid), .wready(b_wready),
        .bresp(b_bresp), .bvalid(b_bvalid), .bready(b_bready));

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s,
                             output logic [1:0] r);
        logic a_ok, w_ok;
        int n;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 50) begin
            a_ok = awready; w_ok = wready;
            tick;
            if (a_ok) awvalid = 1'b0;
            if (w_ok) wvalid = 1'b0;
            n++;
        end
        n = 0;
        while (!bvalid && n < 50) begin tick; n++; end
        chk("wr_bvalid", 64'(bvalid), 64'd1);
        r = bresp;
        tick;
        bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        int n;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (!arready && n < 50) begin tick; n++; end
        tick;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 50) begin tick; n++; end
        chk("rd_rvalid", 64'(rvalid), 64'd1);
        d = rdata; r = rresp;
        tick;
        rready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int n;
        rst = 1'b1; b_rst = 1'b1;
        araddr = '0; arvalid = 0; rready = 0; awaddr = '0; awvalid = 0;
        wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        b_araddr = '0; b_arvalid = 0; b_rready = 0; b_awaddr = '0; b_awvalid = 0;
        b_wdata = '0; b_wstrb = '0; b_wvalid = 0; b_bready = 0;
        tick; tick;
        chk("rst_ready",   64'({arready, awready, wready}), 64'b111);
        chk("rst_valid",   64'({rvalid, bvalid}), 64'b00);
        chk("rst_payload", 64'({rdata, rresp, bresp}), 64'h0);
        chk("b_rst_state", 64'({b_arready, b_awready, b_wready, b_rvalid, b_bvalid}), 64'b11100);
        rst = 1'b0; b_rst = 1'b0;
        tick;

        // Preload, then cycle-exact read with RD_LAT=2
        axi_write(32'h80000000, 32'hDEADBEEF, 8'hFF, r);
        chk("pre_bresp", 64'(r), 64'd0);
        araddr = 32'h80000000; arvalid = 1'b1; rready = 1'b0;
        tick; arvalid = 1'b0;
        chk("rd_c1", 64'({arready, rvalid}), 64'b00);
        tick;
        chk("rd_c2", 64'({arready, rvalid}), 64'b00);
        tick;
        chk("rd_c3", 64'({arready, rvalid, rresp, rdata}), {29'h0, 1'b0, 1'b1, 2'b00, 32'hDEADBEEF});
        rready = 1'b1; tick; rready = 1'b0;
        chk("rd_done", 64'({arready, rvalid}), 64'b10);

        // Byte-strobe write, bvalid three cycles after the handshake cycle
        axi_write(32'h80000004, 32'h11223344, 8'hFF, r);
        awaddr = 32'h80000004; wdata = 32'hAABBCCDD; wstrb = 8'hF5;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        tick; awvalid = 1'b0; wvalid = 1'b0;
        chk("st_c1", 64'({awready, wready, bvalid}), 64'b000);
        tick;
        chk("st_c2", 64'(bvalid), 64'd0);
        tick;
        chk("st_c3", 64'({bvalid, bresp}), 64'b100);
        bready = 1'b1; tick; bready = 1'b0;
        axi_read(32'h80000004, d, r);
        chk("st_rd", 64'({r, d}), {30'h0, 2'b00, 32'h11BB33DD});

        // W before AW
        awaddr = 32'h8000000C; wdata = 32'h0BADF00D; wstrb = 8'h0F;
        wvalid = 1'b1; awvalid = 1'b0;
        tick; wvalid = 1'b0;
        chk("wa_c1", 64'({wready, awready, bvalid}), 64'b010);
        for (int c = 2; c <= 4; c++) begin
            tick;
            chk("wa_nob", 64'({wready, bvalid}), 64'b00);
        end
        awvalid = 1'b1;
        tick; awvalid = 1'b0;
        chk("wa_c5", 64'({awready, wready, bvalid}), 64'b000);
        tick;
        chk("wa_c6", 64'(bvalid), 64'd0);
        tick;
        chk("wa_c7", 64'({bvalid, bresp}), 64'b100);
        bready = 1'b1; tick; bready = 1'b0;
        axi_read(32'h8000000C, d, r);
        chk("wa_rd", 64'({r, d}), {30'h0, 2'b00, 32'h0BADF00D});

        // Out of range; the low-side write would alias the last word if undecoded
        axi_write(32'h80003FFC, 32'h5A5A5A5A, 8'hFF, r);
        chk("top_bresp", 64'(r), 64'd0);
        axi_read(32'h80004000, d, r);
        chk("oor_rd", 64'({r, d}), {30'h0, 2'b10, 32'h0});
        axi_write(32'h7FFFFFFC, 32'hFFFFFFFF, 8'hFF, r);
        chk("oor_bresp", 64'(r), 64'd2);
        axi_read(32'h80003FFC, d, r);
        chk("oor_nowr", 64'({r, d}), {30'h0, 2'b00, 32'h5A5A5A5A});

        // Read backpressure with a competing AR held high
        araddr = 32'h80000004; arvalid = 1'b1; rready = 1'b0;
        tick; araddr = 32'h80000000;
        n = 0;
        while (!rvalid && n < 20) begin tick; n++; end
        chk("bp_r_up", 64'(rvalid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_r_hold", 64'({rvalid, arready, rresp, rdata}), {28'h0, 1'b1, 1'b0, 2'b00, 32'h11BB33DD});
            tick;
        end
        rready = 1'b1; arvalid = 1'b0; tick; rready = 1'b0;
        chk("bp_r_rel", 64'({rvalid, arready}), 64'b01);

        // Write backpressure
        awaddr = 32'h80000010; wdata = 32'h1; wstrb = 8'hFF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        tick; awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin tick; n++; end
        chk("bp_b_up", 64'(bvalid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_b_hold", 64'({bvalid, awready, wready, bresp}), 64'b10000);
            tick;
        end
        bready = 1'b1; tick; bready = 1'b0;
        chk("bp_b_rel", 64'({bvalid, awready, wready}), 64'b011);

        // Second instance: WR_LAT=3 timing, RD_LAT=0 timing
        b_awaddr = 32'h80000008; b_wdata = 32'h12345678; b_wstrb = 8'hFF;
        b_awvalid = 1'b1; b_wvalid = 1'b1; b_bready = 1'b0;
        tick; b_awvalid = 1'b0; b_wvalid = 1'b0;
        chk("b_w_c1", 64'(b_bvalid), 64'd0);
        tick;
        chk("b_w_c2", 64'(b_bvalid), 64'd0);
        tick;
        chk("b_w_c3", 64'(b_bvalid), 64'd0);
        tick;
        chk("b_w_c4", 64'({b_bvalid, b_bresp}), 64'b100);
        b_bready = 1'b1; tick; b_bready = 1'b0;
        b_araddr = 32'h80000008; b_arvalid = 1'b1;
        tick; b_arvalid = 1'b0;
        chk("b_rd0", 64'({b_rvalid, b_arready, b_rresp, b_rdata}), {28'h0, 1'b1, 1'b0, 2'b00, 32'h12345678});
        b_rready = 1'b1; tick; b_rready = 1'b0;

        // Reset in the second wait cycle discards the write
        b_wdata = 32'hCAFEF00D;
        b_awvalid = 1'b1; b_wvalid = 1'b1;
        tick; b_awvalid = 1'b0; b_wvalid = 1'b0;
        tick; b_rst = 1'b1;
        tick; b_rst = 1'b0;
        chk("b_mid_rst", 64'({b_bvalid, b_arready, b_awready, b_wready}), 64'b0111);
        for (int i = 0; i < 5; i++) tick;
        chk("b_mid_nob", 64'(b_bvalid), 64'd0);
        b_araddr = 32'h80000008; b_arvalid = 1'b1;
        tick; b_arvalid = 1'b0;
        chk("b_mid_mem", 64'({b_rvalid, b_rresp, b_rdata}), {29'h0, 1'b1, 2'b00, 32'h12345678});
        b_rready = 1'b1; tick; b_rready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
